// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with configurable word width, parity
// and stop bits, plus a valid/ready output register with overrun detection.
module uart_rx_frame #(
    parameter int DATA_BITS  = 16,
    parameter int OS         = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx,
    input  logic                 rx_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_done,
    output logic                 busy,
    output logic [2:0]           dbg_state
);
    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_q;
    logic                 r_ferr_q;
    logic                 r_ovr;
    logic                 r_done;

    logic w_rxs;
    logic w_tick_last;
    logic w_commit;
    logic w_hs;
    logic w_ferr_next;

    assign w_rxs       = r_sync[1];
    assign w_tick_last = rx_tick && (r_tick == TICK_LAST);
    assign w_commit    = enable && (r_state == STOP) && w_tick_last && (r_bit == STOP_LAST);
    assign w_hs        = r_valid && rx_ready;
    assign w_ferr_next = r_ferr | ~w_rxs;

    // Receive FSM; everything here freezes while enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sync  <= 2'b11;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else if (enable) begin
            r_sync <= {r_sync[0], rx};
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_tick  <= '0;
                    end
                end
                START: begin
                    if (rx_tick) begin
                        if (r_tick == TICK_MID) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                            end else begin
                                r_state <= DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                                r_par   <= 1'b0;
                                r_perr  <= 1'b0;
                                r_ferr  <= 1'b0;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_rxs;
                        if (r_bit == DATA_LAST) begin
                            r_bit   <= '0;
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end else if (rx_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                PARITY: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_perr  <= r_par ^ w_rxs ^ ODD;
                        r_state <= STOP;
                    end else if (rx_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                STOP: begin
                    if (w_tick_last) begin
                        r_tick <= '0;
                        r_ferr <= w_ferr_next;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            // A low final stop sample means a break: wait for idle before rearming.
                            r_state <= w_rxs ? IDLE : WAIT_HIGH;
                        end else begin
                            r_bit <= r_bit + BW'(1);
                        end
                    end else if (rx_tick) begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register: a commit coinciding with a handshake replaces the held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr_q <= 1'b0;
            r_ferr_q <= 1'b0;
            r_ovr    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                if (!r_valid || w_hs) begin
                    r_data   <= r_shift;
                    r_valid  <= 1'b1;
                    r_perr_q <= r_perr;
                    r_ferr_q <= w_ferr_next;
                    if (w_hs) begin
                        r_ovr <= 1'b0;
                    end
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_q;
    assign frame_err  = r_ferr_q;
    assign overrun    = r_ovr;
    assign rx_done    = r_done;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a 16-bit default instance and an 8-bit even-parity,
// two-stop-bit instance, driven by frame-level tasks and checked against a word-level model.
module tb_uart_rx_frame;
    localparam int OS0 = 16;
    localparam int OS1 = 8;
    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_WAIT_HIGH = 32'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  tcnt = 2'd0;
    logic        rx_tick;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    logic        ready0 = 1'b0;
    logic        ready1 = 1'b0;

    logic [15:0] rx_data0;
    logic        valid0, perr0, ferr0, ovr0, done0, busy0;
    logic [2:0]  dbg0;
    logic [7:0]  rx_data1;
    logic        valid1, perr1, ferr1, ovr1, done1, busy1;
    logic [2:0]  dbg1;

    int n_vec = 0;
    int n_err = 0;
    int n_done0 = 0;
    int n_done1 = 0;

    // word-level model of each receiver's output side
    int          m_done [2];
    bit          m_valid [2];
    bit          m_ovr [2];
    bit          m_perr [2];
    bit          m_ferr [2];
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    uart_rx_frame #(.DATA_BITS(16), .OS(OS0), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx0), .rx_tick(rx_tick),
        .rx_data(rx_data0), .rx_valid(valid0), .rx_ready(ready0), .parity_err(perr0),
        .frame_err(ferr0), .overrun(ovr0), .rx_done(done0), .busy(busy0), .dbg_state(dbg0)
    );

    uart_rx_frame #(.DATA_BITS(8), .OS(OS1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx1), .rx_tick(rx_tick),
        .rx_data(rx_data1), .rx_valid(valid1), .rx_ready(ready1), .parity_err(perr1),
        .frame_err(ferr1), .overrun(ovr1), .rx_done(done1), .busy(busy1), .dbg_state(dbg1)
    );

    // clock, baud tick (one clk in four) and rx_done pulse counters
    always #5 clk = ~clk;
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign rx_tick = (tcnt == 2'd3);

    always @(negedge clk) begin
        if (done0) n_done0 <= n_done0 + 1;
        if (done1) n_done1 <= n_done1 + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic set_ready(input int sel, input logic v);
        if (sel == 0) ready0 = v;
        else ready1 = v;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!rx_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic q_push(input int sel, input logic [15:0] w);
        if (sel == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
    endtask

    task automatic q_pop(input int sel);
        logic [15:0] w;
        if (sel == 0) begin
            if (exp_q0.size() > 0) w = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() > 0) w = exp_q1.pop_front();
        end
    endtask

    task automatic model_commit(input int sel, input logic [15:0] w, input bit pe, input bit fe, input bit hs);
        m_done[sel]++;
        if (m_valid[sel] && !hs) begin
            m_ovr[sel] = 1'b1;
        end else begin
            if (m_valid[sel]) begin
                m_ovr[sel] = 1'b0;
                q_pop(sel);
            end
            q_push(sel, w);
            m_valid[sel] = 1'b1;
            m_perr[sel]  = pe;
            m_ferr[sel]  = fe;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 1'b0;
            m_ovr[s]   = 1'b0;
            m_perr[s]  = 1'b0;
            m_ferr[s]  = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Drives one frame on the selected line; leaves the line at the last stop level.
    task automatic send_frame(input int sel, input logic [15:0] d, input logic p,
                              input logic [1:0] st, input bit hs, input int pause_bit);
        int os = (sel == 0) ? OS0 : OS1;
        int db = (sel == 0) ? 16 : 8;
        int ns = (sel == 0) ? 1 : 2;
        logic [15:0] w;
        bit pe;
        bit fe;
        set_line(sel, 1'b0);
        wait_ticks(os);
        for (int i = 0; i < db; i++) begin
            set_line(sel, d[i]);
            if (i == pause_bit) begin
                enable = 1'b0;
                repeat (50) @(posedge clk);
                #1;
                enable = 1'b1;
            end
            wait_ticks(os);
        end
        if (sel == 1) begin
            set_line(sel, p);
            wait_ticks(os);
        end
        for (int s = 0; s < ns; s++) begin
            set_line(sel, st[s]);
            if (s == ns - 1 && hs) begin
                wait_ticks(os / 2 - 1);
                @(negedge clk);
                while (!rx_tick) @(negedge clk);
                set_ready(sel, 1'b1);
                @(posedge clk);
                #1;
                set_ready(sel, 1'b0);
                wait_ticks(os / 2);
            end else begin
                wait_ticks(os);
            end
        end
        w  = (sel == 0) ? d : {8'h00, d[7:0]};
        pe = (sel == 1) ? ((^d[7:0]) ^ p) : 1'b0;
        fe = (sel == 1) ? ~(st[0] & st[1]) : ~st[0];
        model_commit(sel, w, pe, fe, hs);
    endtask

    task automatic frame(input int sel, input logic [15:0] d, input logic p,
                         input logic [1:0] st, input bit hs, input int pause_bit);
        send_frame(sel, d, p, st, hs, pause_bit);
        set_line(sel, 1'b1);
        wait_ticks(2);
    endtask

    task automatic check_out(input int sel, input string tag);
        logic [15:0] d;
        logic v, pe, fe, ov;
        int nd;
        @(negedge clk);
        if (sel == 0) begin
            d = rx_data0; v = valid0; pe = perr0; fe = ferr0; ov = ovr0; nd = n_done0;
        end else begin
            d = {8'h00, rx_data1}; v = valid1; pe = perr1; fe = ferr1; ov = ovr1; nd = n_done1;
        end
        check_eq({tag, ".valid"}, v, m_valid[sel]);
        if (m_valid[sel]) begin
            if (sel == 0) check_eq({tag, ".data"}, d, exp_q0[0]);
            else check_eq({tag, ".data"}, d, exp_q1[0]);
            check_eq({tag, ".perr"}, pe, m_perr[sel]);
            check_eq({tag, ".ferr"}, fe, m_ferr[sel]);
        end
        check_eq({tag, ".ovr"}, ov, m_ovr[sel]);
        check_eq({tag, ".done"}, nd, m_done[sel]);
    endtask

    task automatic consume(input int sel, input string tag);
        @(negedge clk);
        set_ready(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ready(sel, 1'b0);
        if (m_valid[sel]) begin
            m_valid[sel] = 1'b0;
            m_ovr[sel]   = 1'b0;
            q_pop(sel);
        end
        check_out(sel, tag);
    endtask

    initial begin
        logic [15:0] d;
        logic        p;
        logic [1:0]  st;
        model_reset();
        m_done[0] = 0;
        m_done[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.data0", rx_data0, 0);
        check_eq("rst.valid0", valid0, 0);
        check_eq("rst.flags0", {perr0, ferr0, ovr0, done0, busy0}, 0);
        check_eq("rst.state0", dbg0, ST_IDLE);
        check_eq("rst.out1", {rx_data1, valid1, perr1, ferr1, ovr1, done1, busy1}, 0);
        reset = 1'b0;
        wait_ticks(2);

        frame(0, 16'hA5C3, 1'b0, 2'b11, 1'b0, -1);
        check_out(0, "a5c3");
        consume(0, "a5c3_hs");

        set_line(0, 1'b0);
        wait_ticks(3);
        set_line(0, 1'b1);
        wait_ticks(OS0);
        check_out(0, "glitch");
        check_eq("glitch.state", dbg0, ST_IDLE);

        send_frame(0, 16'($urandom), 1'b0, 2'b00, 1'b0, -1);
        wait_ticks(40);
        check_out(0, "break");
        check_eq("break.state", dbg0, ST_WAIT_HIGH);
        set_line(0, 1'b1);
        wait_ticks(2);
        check_eq("break.idle", dbg0, ST_IDLE);
        consume(0, "break_hs");

        frame(0, 16'h1111, 1'b0, 2'b11, 1'b0, -1);
        frame(0, 16'h2222, 1'b0, 2'b11, 1'b0, -1);
        check_out(0, "ovr");
        consume(0, "ovr_hs");

        frame(0, 16'h3333, 1'b0, 2'b11, 1'b0, -1);
        frame(0, 16'h5555, 1'b0, 2'b11, 1'b0, -1);
        frame(0, 16'h4444, 1'b0, 2'b11, 1'b1, -1);
        check_out(0, "coinc");
        consume(0, "coinc_hs");

        frame(0, 16'h6A9C, 1'b0, 2'b11, 1'b0, 5);
        check_out(0, "pause");

        set_line(0, 1'b0);
        wait_ticks(OS0);
        for (int i = 0; i < 4; i++) begin
            set_line(0, i[0]);
            wait_ticks(OS0);
        end
        check_eq("mid.busy", busy0, 1);
        reset = 1'b1;
        #1;
        check_eq("mid.data0", rx_data0, 0);
        check_eq("mid.flags0", {valid0, perr0, ferr0, ovr0, done0, busy0}, 0);
        check_eq("mid.state0", dbg0, ST_IDLE);
        set_line(0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        wait_ticks(2);

        frame(1, 16'h0037, 1'b1, 2'b11, 1'b0, -1);
        check_out(1, "p37ok");
        consume(1, "p37ok_hs");
        frame(1, 16'h0037, 1'b0, 2'b11, 1'b0, -1);
        check_out(1, "p37bad");
        consume(1, "p37bad_hs");

        for (int k = 0; k < 24; k++) begin
            d  = 16'($urandom_range(0, 255));
            p  = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            frame(1, d, p, st, 1'b0, -1);
            check_out(1, "rnd1");
            if ($urandom_range(0, 1) == 1) consume(1, "rnd1_hs");
        end

        for (int k = 0; k < 5; k++) begin
            d  = 16'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            frame(0, d, 1'b0, st, 1'b0, -1);
            check_out(0, "rnd0");
            if ($urandom_range(0, 1) == 1) consume(0, "rnd0_hs");
        end
        consume(0, "end0");
        consume(1, "end1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that supersedes the fixed 16-bit, no-parity receiver in the serial command path. It oversamples the line on an external baud tick and supports configurable word width, oversampling ratio, optional parity and one or two stop bits. It adds false-start rejection, parity and framing error detection, and a valid/ready output register with overrun detection, so a downstream FIFO or command decoder can apply backpressure.

## Interface
- DATA_BITS, 16: word width, 5..16; LSB received first.
- OS, 16: rx_tick pulses per bit, even, 8..16.
- PARITY_EN, 0: 1 = parity bit follows data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored if PARITY_EN=0.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  gates the receive FSM, counters and synchroniser; the output handshake is not gated.
- rx  in  1  asynchronous serial line, idle high.
- rx_tick  in  1  one-clk baud-oversample strobe, OS per bit.
- rx_data  out  DATA_BITS  held received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts; transfer when rx_valid && rx_ready.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  a stop bit sampled low for the held word.
- overrun  out  1  sticky; a word was dropped because rx_valid was still set.
- rx_done  out  1  one-clk pulse per completed frame, including dropped frames.
- busy  out  1  FSM not in IDLE.

## Operation
- The 2-flop synchroniser on rx (reset value 1, advances only when enable=1) feeds rxs. All FSM sampling uses rxs.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rxs=0 -> START with tick_count=0.
- START: advances on rx_tick. At tick_count==OS/2-1, if rxs=1 (false start) -> IDLE with no flags and no rx_done. Otherwise -> DATA with tick_count=0 and bit_count=0.
- DATA: at tick_count==OS-1, shift rxs in at the MSB (shift right), XOR it into the running parity, and set tick_count=0. After DATA_BITS bits -> PARITY if PARITY_EN, else STOP. Samples therefore land at mid-bit.
- PARITY: sample at OS-1. Error if data XOR parity bit XOR PARITY_ODD is 1. -> STOP.
- STOP: sample each stop bit at OS-1 and OR any low sample into the frame error. After STOP_BITS bits, commit the frame. Then -> IDLE if the last sample was 1, else -> WAIT_HIGH.
- WAIT_HIGH: remain until rxs=1, then -> IDLE. This prevents a break condition from retriggering a start.
- Commit: rx_done pulses.
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid=1.
  - Else: drop the new word, keep the held word and flags, and set overrun=1.
- A handshake with no commit in the same cycle clears rx_valid. overrun clears only on reset or on the next successful handshake.
- Counter widths: tick_count is $clog2(OS) bits and bit_count is $clog2(DATA_BITS+1) bits, with no wrap inside a bit.
- enable=0 holds the FSM, counters and shift register. A frame in progress resumes when enable returns.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, rx_done=0, busy=0; FSM in IDLE.
- Line-to-FSM latency: 2 clk for the synchroniser, plus 1 clk for the IDLE->START transition.
- Commit happens in the clk after the rx_tick carrying the final stop sample. rx_valid, rx_data and the flags update on that same edge, and rx_done is high for that cycle only.
- Frame length: about (1 + DATA_BITS + PARITY_EN + STOP_BITS) × OS ticks; the start phase is OS/2 ticks.
- Reset mid-frame forces IDLE immediately and discards the partial word.

## Test plan
- Defaults, frame 0xA5C3 with a valid stop bit, rx_ready=0 -> rx_data=0xA5C3, rx_valid=1, one rx_done pulse, no flags. Then rx_ready=1 for 1 clk -> rx_valid=0.
- DATA_BITS=8, PARITY_EN=1, even parity: 0x37 with parity 1 -> parity_err=0. 0x37 with parity 0 -> parity_err=1, word still delivered.
- Low glitch of 3 ticks (< OS/2) -> returns to IDLE, no rx_done, rx_valid unchanged.
- Stop bit held low, then line low for 40 ticks -> frame_err=1, FSM in WAIT_HIGH, no new start until the line returns high.
- Two frames 0x1111 and 0x2222 with rx_ready=0 -> rx_data=0x1111, overrun=1, rx_done pulsed twice. Handshake -> rx_valid=0, overrun=0. Commit coincident with a handshake -> new word loaded, no overrun.
- Reset asserted mid-DATA; enable=0 for 50 clk mid-frame -> reset gives all outputs 0 and IDLE; the enable pause resumes and decodes the frame correctly.
